// File: rtl/ram_arbiter_pkg.sv
// Shared widths, FSM encodings and port ids for ram_arbiter.
// These macros stand in for the project's define.v.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef STATE_IDLE
`define STATE_IDLE 2'd0
`endif
`ifndef STATE_ISSUE
`define STATE_ISSUE 2'd1
`endif
`ifndef STATE_RESP
`define STATE_RESP 2'd2
`endif
`ifndef PORT_IF
`define PORT_IF 1'b0
`endif
`ifndef PORT_DT
`define PORT_DT 1'b1
`endif

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = `STATE_IDLE,
    ISSUE = `STATE_ISSUE,
    RESP  = `STATE_RESP
  } state_t;

  localparam logic PORT_IF = `PORT_IF;
  localparam logic PORT_DT = `PORT_DT;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a fetch port and a data port.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise ties go to the data port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// Handshake: a port raises req with wen/addr/wdata and holds it until its
// one-cycle ack; inputs are sampled only in IDLE, and rdata is valid only with ack.
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic                   if_wen,
  input  logic [`ADDR_WIDTH-1:0] if_addr,
  input  logic [`DATA_WIDTH-1:0] if_wdata,
  output logic                   if_ack,
  output logic [`DATA_WIDTH-1:0] if_rdata,
  input  logic                   dt_req,
  input  logic                   dt_wen,
  input  logic [`ADDR_WIDTH-1:0] dt_addr,
  input  logic [`DATA_WIDTH-1:0] dt_wdata,
  output logic                   dt_ack,
  output logic [`DATA_WIDTH-1:0] dt_rdata,
  output logic                   ram_en,
  output logic                   ram_wen,
  output logic [`ADDR_WIDTH-1:0] ram_addr,
  output logic [`DATA_WIDTH-1:0] ram_write,
  input  logic [`DATA_WIDTH-1:0] ram_read,
  output logic [1:0]             fsm_state
);

  state_t                 state;
  state_t                 state_next;
  logic                   lat_wen;
  logic [`ADDR_WIDTH-1:0] lat_addr;
  logic [`DATA_WIDTH-1:0] lat_wdata;
  logic                   lat_port;
  logic                   grant_port;
  logic                   sel_wen;
  logic [`ADDR_WIDTH-1:0] sel_addr;
  logic [`DATA_WIDTH-1:0] sel_wdata;
  logic                   take;

`ifdef RAM_ARB_RR_EN
  logic                   last_port;
`endif

  assign take      = (state == IDLE) && (if_req || dt_req);
  assign fsm_state = state;

  always_comb begin
    grant_port = PORT_IF;
    if (dt_req && !if_req) begin
      grant_port = PORT_DT;
    end else if (dt_req && if_req) begin
`ifdef RAM_ARB_RR_EN
      // Tie goes to whichever port was not served last.
      grant_port = (last_port == PORT_DT) ? PORT_IF : PORT_DT;
`else
      grant_port = PORT_DT;
`endif
    end
  end

  always_comb begin
    sel_wen   = if_wen;
    sel_addr  = if_addr;
    sel_wdata = if_wdata;
    if (grant_port == PORT_DT) begin
      sel_wen   = dt_wen;
      sel_addr  = dt_addr;
      sel_wdata = dt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_port  <= PORT_IF;
`ifdef RAM_ARB_RR_EN
      last_port <= PORT_DT;
`endif
    end else begin
      state <= state_next;
      if (take) begin
        lat_wen   <= sel_wen;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_port  <= grant_port;
`ifdef RAM_ARB_RR_EN
        last_port <= grant_port;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || dt_req) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM drive only in ISSUE; ack and read data only in RESP.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_write = '0;
    if_ack    = 1'b0;
    dt_ack    = 1'b0;
    if_rdata  = '0;
    dt_rdata  = '0;
    if (state == ISSUE) begin
      ram_en    = 1'b1;
      ram_wen   = lat_wen;
      ram_addr  = lat_addr;
      ram_write = lat_wdata;
    end
    if (state == RESP) begin
      if (lat_port == PORT_DT) begin
        dt_ack = 1'b1;
        if (!lat_wen) dt_rdata = ram_read;
      end else begin
        if_ack = 1'b1;
        if (!lat_wen) if_rdata = ram_read;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference (grant rule, reference memory, expected-data queue).
module tb_ram_arbiter;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req, if_wen, dt_req, dt_wen;
  logic [15:0] if_addr, dt_addr;
  logic [7:0]  if_wdata, dt_wdata;
  logic        if_ack, dt_ack;
  logic [7:0]  if_rdata, dt_rdata;
  logic        ram_en, ram_wen;
  logic [15:0] ram_addr;
  logic [7:0]  ram_write, ram_read;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_wen(if_wen), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dt_req(dt_req), .dt_wen(dt_wen), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_ack(dt_ack), .dt_rdata(dt_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_write(ram_write), .ram_read(ram_read), .fsm_state(fsm_state)
  );

  // Preloaded content of the RAM before any write.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'h0005) ? 8'h3C : (a[7:0] ^ 8'hC3);
  endfunction

  // RAM model (owned by the parent, never reset): registered read.
  logic [7:0] mem     [65536];
  logic       written [65536];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen) begin
        mem[ram_addr]     <= ram_write;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_read <= (written[ram_addr] === 1'b1) ? mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {12'b0, ram_en, ram_wen, if_ack, dt_ack, ram_addr}, 32'h0);
    check({tag, "_dat"}, {8'b0, ram_write, if_rdata, dt_rdata}, 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; dt_req = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // port: 0 = fetch, 1 = data, 2 = no ack within budget
  task automatic wait_ack(input int budget, output int port, output logic [7:0] data);
    port = 2; data = 8'h00;
    for (int i = 0; i < budget && port == 2; i++) begin
      @(negedge clk);
      check("ack_exclusive", {31'b0, if_ack & dt_ack}, 32'h0);
      if (if_ack) begin port = 0; data = if_rdata; end
      else if (dt_ack) begin port = 1; data = dt_rdata; end
    end
    check("ack_seen", {31'b0, port != 2}, 32'h1);
  endtask

  // ---------------- scoreboard / reference model state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  ref_mem [512];
  int          st;
  logic        win_dt, last_dt, pend_if, pend_dt;
  logic        m_wen;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;

  initial begin
    int         p;
    logic [7:0] d;
    logic [7:0] e;

    rst = 1'b1;
    if_req = 1'b0; if_wen = 1'b0; if_addr = '0; if_wdata = '0;
    dt_req = 1'b0; dt_wen = 1'b0; dt_addr = '0; dt_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset held two cycles with both requests high.
    rst = 1'b1; if_req = 1'b1; dt_req = 1'b1;
    if_wen = 1'b0; dt_wen = 1'b0; if_addr = 16'h0005; dt_addr = 16'h0006;
    @(negedge clk); check_quiet("rst_c1");
    @(negedge clk); check_quiet("rst_c2");
    check("rst_state", {30'b0, fsm_state}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_post1_acks", {30'b0, if_ack, dt_ack}, 32'h0);
    check("rst_post1_en", {31'b0, ram_en}, 32'h1);
    @(negedge clk);
    check("rst_first_grant", {30'b0, if_ack, dt_ack}, RR ? 32'h2 : 32'h1);
    check("rst_first_data", {24'b0, if_rdata | dt_rdata}, RR ? 32'h3C : {24'b0, init_val(16'h0006)});
    if_req = 1'b0; dt_req = 1'b0;
    @(negedge clk);

    // Single fetch read with cycle-exact timing.
    do_reset(1);
    if_req = 1'b1; if_wen = 1'b0; if_addr = 16'h0005;
    @(negedge clk);
    check("rd_issue_en", {31'b0, ram_en}, 32'h1);
    check("rd_issue_addr", {16'b0, ram_addr}, 32'h5);
    check("rd_issue_ack", {31'b0, if_ack}, 32'h0);
    @(negedge clk);
    check("rd_ack", {31'b0, if_ack}, 32'h1);
    check("rd_data", {24'b0, if_rdata}, 32'h3C);
    check("rd_dt_ack", {31'b0, dt_ack}, 32'h0);
    if_req = 1'b0;
    @(negedge clk); check_quiet("rd_after");

    // Data-port write then read-back; req stays high across acks.
    do_reset(1);
    dt_req = 1'b1; dt_wen = 1'b1; dt_addr = 16'h0010; dt_wdata = 8'hA5;
    @(negedge clk);
    check("wr_issue", {14'b0, ram_en, ram_wen, ram_addr}, {14'b0, 2'b11, 16'h0010});
    check("wr_issue_data", {24'b0, ram_write}, 32'hA5);
    @(negedge clk);
    check("wr_ack", {31'b0, dt_ack}, 32'h1);
    check("wr_ack_rdata", {24'b0, dt_rdata}, 32'h0);
    dt_wen = 1'b0;
    @(negedge clk); check_quiet("wr_gap");
    wait_ack(4, p, d);
    check("rb_port", p, 32'h1);
    check("rb_data", {24'b0, d}, 32'hA5);
    dt_req = 1'b0;
    @(negedge clk);

    // Tie held across four accesses.
    do_reset(1);
    if_req = 1'b1; if_wen = 1'b0; if_addr = 16'h0030;
    dt_req = 1'b1; dt_wen = 1'b0; dt_addr = 16'h0031;
    for (int k = 0; k < 4; k++) begin
      wait_ack(6, p, d);
      check($sformatf("tie_grant_%0d", k), p, RR ? (k % 2) : 1);
      check($sformatf("tie_data_%0d", k), {24'b0, d},
            {24'b0, init_val((p == 0) ? 16'h0030 : 16'h0031)});
    end
    if_req = 1'b0; dt_req = 1'b0;
    @(negedge clk);

    // Address change during ISSUE must not reach the RAM.
    do_reset(1);
    dt_req = 1'b1; dt_wen = 1'b0; dt_addr = 16'h0001;
    @(negedge clk);
    dt_addr = 16'h0002;
    #1 check("hold_addr", {16'b0, ram_addr}, 32'h1);
    @(negedge clk);
    check("hold_data", {24'b0, dt_rdata}, {24'b0, init_val(16'h0001)});
    dt_req = 1'b0;
    @(negedge clk);

    // Reset during the ISSUE cycle of a write.
    do_reset(1);
    dt_req = 1'b1; dt_wen = 1'b1; dt_addr = 16'h0020; dt_wdata = 8'h77;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ack", {31'b0, dt_ack}, 32'h0);
    check("rstw_state", {30'b0, fsm_state}, 32'h0);
    check("rstw_en", {30'b0, ram_en, ram_wen}, 32'h0);
    rst = 1'b0; dt_req = 1'b0;
    if_req = 1'b1; if_wen = 1'b0; if_addr = 16'h0020;
    wait_ack(4, p, d);
    check("rstw_port", p, 32'h0);
    check("rstw_mem", {24'b0, d}, 32'h77);
    if_req = 1'b0;
    @(negedge clk);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(16'(i));
    do_reset(1);
    st = 0; last_dt = 1'b1; pend_if = 1'b0; pend_dt = 1'b0; win_dt = 1'b0;
    m_wen = 1'b0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      check("r_ram_en", {31'b0, ram_en}, {31'b0, st == 1});
      check("r_ram_wen", {31'b0, ram_wen}, {31'b0, st == 1 && m_wen});
      check("r_ram_addr", {16'b0, ram_addr}, (st == 1) ? {16'b0, m_addr} : 32'h0);
      check("r_ram_write", {24'b0, ram_write}, (st == 1) ? {24'b0, m_wdata} : 32'h0);
      check("r_if_ack", {31'b0, if_ack}, {31'b0, st == 2 && !win_dt});
      check("r_dt_ack", {31'b0, dt_ack}, {31'b0, st == 2 && win_dt});
      if (st == 2) begin
        e = exp_q.pop_front();
        check("r_rdata", {24'b0, win_dt ? dt_rdata : if_rdata}, {24'b0, e});
        check("r_other_rdata", {24'b0, win_dt ? if_rdata : dt_rdata}, 32'h0);
        if (win_dt) pend_dt = 1'b0; else pend_if = 1'b0;
      end else begin
        check("r_rdata_quiet", {16'b0, if_rdata, dt_rdata}, 32'h0);
      end

      if (!pend_if && $urandom_range(0, 2) != 0) begin
        pend_if = 1'b1;
        if_wen = 1'($urandom_range(0, 1));
        if_addr = 16'h0100 | 16'($urandom_range(0, 15));
        if_wdata = 8'($urandom_range(0, 255));
      end
      if (!pend_dt && $urandom_range(0, 2) != 0) begin
        pend_dt = 1'b1;
        dt_wen = 1'($urandom_range(0, 1));
        dt_addr = 16'h0100 | 16'($urandom_range(0, 15));
        dt_wdata = 8'($urandom_range(0, 255));
      end
      if (st == 1) begin
        // Granted port wiggles its fields mid-access; must be ignored.
        if (win_dt) begin
          dt_wen = 1'($urandom_range(0, 1));
          dt_addr = 16'h0100 | 16'($urandom_range(0, 15));
          dt_wdata = 8'($urandom_range(0, 255));
        end else begin
          if_wen = 1'($urandom_range(0, 1));
          if_addr = 16'h0100 | 16'($urandom_range(0, 15));
          if_wdata = 8'($urandom_range(0, 255));
        end
      end
      if_req = pend_if;
      dt_req = pend_dt;

      // Transaction-level step: one access occupies three cycles.
      if (st == 0) begin
        if (pend_if || pend_dt) begin
          if (pend_if && pend_dt) win_dt = RR ? !last_dt : 1'b1;
          else win_dt = pend_dt;
          last_dt = win_dt;
          m_wen   = win_dt ? dt_wen : if_wen;
          m_addr  = win_dt ? dt_addr : if_addr;
          m_wdata = win_dt ? dt_wdata : if_wdata;
          if (m_wen) begin
            exp_q.push_back(8'h00);
            ref_mem[m_addr[8:0]] = m_wdata;
          end else begin
            exp_q.push_back(ref_mem[m_addr[8:0]]);
          end
          st = 1;
        end
      end else if (st == 1) begin
        st = 2;
      end else begin
        st = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters: none; widths SHALL come from `ADDR_WIDTH (16) and `DATA_WIDTH (8) in define.v.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_req  input  1  instruction-fetch port requests an access; held until if_ack.
REQ-005 if_wen  input  1  fetch port: 1 = write, 0 = read.
REQ-006 if_addr  input  `ADDR_WIDTH  fetch port address.
REQ-007 if_wdata  input  `DATA_WIDTH  fetch port write data.
REQ-008 if_ack  output  1  one-cycle pulse; fetch access complete.
REQ-009 if_rdata  output  `DATA_WIDTH  fetch read data; valid only while if_ack=1.
REQ-010 dt_req, dt_wen, dt_addr, dt_wdata, dt_ack, dt_rdata SHALL mirror REQ-004..009 for the data (tape) port.
REQ-011 ram_en, ram_wen  output  1  drive ram en/wen.
REQ-012 ram_addr  output  `ADDR_WIDTH, ram_write  output  `DATA_WIDTH  drive ram addr/write.
REQ-013 ram_read  input  `DATA_WIDTH  ram read data, valid the cycle after ram_en=1 with ram_wen=0.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP; one access per 3 cycles.
REQ-015 IDLE: if any req=1, SHALL choose winner (REQ-020), latch its wen/addr/wdata plus winner id, go to ISSUE; else stay in IDLE.
REQ-016 ISSUE: ram_en=1, ram_wen/ram_addr/ram_write = latched values; next state RESP.
REQ-017 RESP: winner's ack=1 for exactly one cycle; for reads, winner's rdata = ram_read; for writes, rdata = 0; next state IDLE.
REQ-018 Outside ISSUE, ram_en=0, ram_wen=0. Outside RESP, both acks=0 and both rdata=0.
REQ-019 Requester inputs SHALL be sampled only in IDLE; changes during ISSUE/RESP have no effect. A req still high in the IDLE cycle after its ack is a new request.
REQ-020 Arbitration in IDLE: with one req, that port wins; with both, per REQ-024/025.
REQ-021 Never both acks high in the same cycle.

Reset
REQ-022 On rst: state=IDLE, latched wen/addr/wdata=0, last-grant=dt (so if wins first tie), all outputs 0 at the next edge.
REQ-023 rst mid-operation SHALL discard the transaction without ack. A write whose ISSUE cycle coincides with rst is still performed by ram (ram is not reset).

Configuration
REQ-024 With RAM_ARB_RR_EN defined: ties SHALL be granted to the port not granted most recently; last-grant SHALL update on every grant.
REQ-025 Without RAM_ARB_RR_EN: ties SHALL always go to dt; no last-grant register.

Structure
REQ-026 FSM state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and port ids (PORT_IF=0, PORT_DT=1) SHALL be defined in define.v.
REQ-027 Single flat module, no sub-module; ram SHALL be instantiated by the parent, not inside ram_arbiter.

Verification
REQ-028 Reset: rst=1 for 2 cycles with both reqs high -> all outputs 0, no ack until 3 cycles after rst falls.
REQ-029 Single read: ram preloaded with data[5]=8'h3C; if_req, if_addr=16'h0005, if_wen=0 -> ram_en=1 in cycle 2, if_ack=1 with if_rdata=8'h3C in cycle 3.
REQ-030 Write then read: dt writes 8'hA5 to 16'h0010, then reads 16'h0010 -> dt_rdata=8'hA5 on second dt_ack; dt_rdata=0 on write ack.
REQ-031 Tie: both req held for 4 accesses -> with RAM_ARB_RR_EN grants if,dt,if,dt; without, dt,dt,dt,dt while dt_req held.
REQ-032 Input change: dt_addr changed from 16'h0001 to 16'h0002 during ISSUE -> ram_addr stays 16'h0001.
REQ-033 Reset mid-write: rst asserted during ISSUE of dt write 8'h77 to 16'h0020 -> no dt_ack, state IDLE; ram data[16'h0020]=8'h77.
